pc_branch_unit: RTL and testbench

Parametrised program-counter and branch unit for the SAP-2 datapath. It replaces the fixed 8-bit program counter plus single-flag jump logic with four mechanisms: a full condition-code evaluator (JMP/JZ/JNZ/JC/JNC/JN/JNN), conditional CALL, RET through a hardware return-address stack, and a halt latch. It sits between the control unit (which issues increment, load, call, ret and halt strobes) and the ALU flag register, and it drives the memory address path with `counter_out`.

---
 rtl/pc_branch_unit.sv | 107 ++++++++++
 tb/tb_pc_branch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Program counter with condition-code jumps, conditional call, hardware
// return-address stack and a halt latch for the SAP-2 datapath.
module pc_branch_unit #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pc_enable_i,
    input  logic                             load_i,
    input  logic                             call_i,
    input  logic                             ret_i,
    input  logic                             halt_i,
    input  logic [2:0]                       cond_i,
    input  logic [ADDR_WIDTH-1:0]            target_i,
    input  logic                             flag_zero_i,
    input  logic                             flag_carry_i,
    input  logic                             flag_negative_i,
    output logic [ADDR_WIDTH-1:0]            counter_out,
    output logic                             taken_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth_o,
    output logic                             stack_overflow_o,
    output logic                             stack_underflow_o,
    output logic                             halted_o
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic                  cond_true;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  do_push;
    logic [IW-1:0]         push_idx;
    logic [IW-1:0]         top_idx;

    always_comb begin
        cond_true = 1'b0;
        case (cond_i)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flag_zero_i;
            3'b010:  cond_true = !flag_zero_i;
            3'b011:  cond_true = flag_carry_i;
            3'b100:  cond_true = !flag_carry_i;
            3'b101:  cond_true = flag_negative_i;
            3'b110:  cond_true = !flag_negative_i;
            default: cond_true = 1'b0;
        endcase
    end

    assign stack_full  = (depth_o == DW'(STACK_DEPTH));
    assign stack_empty = (depth_o == '0);
    assign push_idx    = IW'(depth_o);
    assign top_idx     = IW'(depth_o - DW'(1));

    // A push only happens when every higher-priority action is absent.
    assign do_push = !reset && !halted_o && !halt_i && !ret_i
                     && call_i && cond_true && !stack_full;

    // Stack contents carry no reset; only depth_o decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_idx] <= counter_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_out       <= '0;
            depth_o           <= '0;
            taken_o           <= 1'b0;
            stack_overflow_o  <= 1'b0;
            stack_underflow_o <= 1'b0;
            halted_o          <= 1'b0;
        end else begin
            taken_o <= 1'b0;
            if (halted_o) begin
                counter_out <= counter_out;
            end else if (halt_i) begin
                halted_o <= 1'b1;
            end else if (ret_i) begin
                if (!stack_empty) begin
                    counter_out <= stack_mem[top_idx];
                    depth_o     <= depth_o - DW'(1);
                    taken_o     <= 1'b1;
                end else begin
                    stack_underflow_o <= 1'b1;
                end
            end else if (call_i && cond_true) begin
                if (!stack_full) begin
                    counter_out <= target_i;
                    depth_o     <= depth_o + DW'(1);
                    taken_o     <= 1'b1;
                end else begin
                    stack_overflow_o <= 1'b1;
                end
            end else if (load_i && cond_true) begin
                counter_out <= target_i;
                taken_o     <= 1'b1;
            end else if (pc_enable_i) begin
                counter_out <= counter_out + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: the driver queues the expected outputs
// after each edge and a monitor compares them on the following falling edge.
module tb_pc_branch_unit;

    logic       clk;
    logic       reset;
    logic       pc_enable_i;
    logic       load_i;
    logic       call_i;
    logic       ret_i;
    logic       halt_i;
    logic [2:0] cond_i;
    logic [7:0] target_i;
    logic       flag_zero_i;
    logic       flag_carry_i;
    logic       flag_negative_i;
    logic [7:0] counter_out;
    logic       taken_o;
    logic [2:0] depth_o;
    logic       stack_overflow_o;
    logic       stack_underflow_o;
    logic       halted_o;

    // {counter, taken, depth, overflow, underflow, halted}
    logic [14:0] exp_q[$];
    string       name_q[$];
    int          vectors;
    int          miscompares;

    pc_branch_unit #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_enable_i       (pc_enable_i),
        .load_i            (load_i),
        .call_i            (call_i),
        .ret_i             (ret_i),
        .halt_i            (halt_i),
        .cond_i            (cond_i),
        .target_i          (target_i),
        .flag_zero_i       (flag_zero_i),
        .flag_carry_i      (flag_carry_i),
        .flag_negative_i   (flag_negative_i),
        .counter_out       (counter_out),
        .taken_o           (taken_o),
        .depth_o           (depth_o),
        .stack_overflow_o  (stack_overflow_o),
        .stack_underflow_o (stack_underflow_o),
        .halted_o          (halted_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic clr();
        reset = 1'b0; pc_enable_i = 1'b0; load_i = 1'b0; call_i = 1'b0;
        ret_i = 1'b0; halt_i = 1'b0; cond_i = 3'b000; target_i = 8'h00;
        flag_zero_i = 1'b0; flag_carry_i = 1'b0; flag_negative_i = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [7:0] pc, input logic tk,
                       input logic [2:0] dp, input logic ov, input logic un,
                       input logic hl);
        @(posedge clk);
        exp_q.push_back({pc, tk, dp, ov, un, hl});
        name_q.push_back(nm);
        #1;
        clr();
    endtask

    task automatic jump_to(input logic [7:0] a, input logic [2:0] dp,
                           input logic ov, input logic un);
        load_i = 1'b1; cond_i = 3'b000; target_i = a;
        cyc("preload", a, 1'b1, dp, ov, un, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [14:0] e;
            logic [14:0] a;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {counter_out, taken_o, depth_o, stack_overflow_o,
                  stack_underflow_o, halted_o};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s: got pc=%h tk=%b dp=%0d ov=%b un=%b hl=%b, wanted pc=%h tk=%b dp=%0d ov=%b un=%b hl=%b",
                         nm, a[14:7], a[6], a[5:3], a[2], a[1], a[0],
                         e[14:7], e[6], e[5:3], e[2], e[1], e[0]);
            end
        end
    end

    // Independent statement of the condition-code table.
    function automatic logic cond_expect(input int code, input int flags);
        logic z, c, n;
        z = flags[2]; c = flags[1]; n = flags[0];
        case (code)
            0: return 1'b1;
            1: return z == 1'b1;
            2: return z == 1'b0;
            3: return c == 1'b1;
            4: return c == 1'b0;
            5: return n == 1'b1;
            6: return n == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr();
        @(posedge clk);
        #1;
        do_reset();

        // JN taken, then JN not taken with fetch increment.
        jump_to(8'h05, 3'd0, 1'b0, 1'b0);
        load_i = 1'b1; cond_i = 3'b101; target_i = 8'h06; flag_negative_i = 1'b1;
        cyc("jn_taken", 8'h06, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc("taken_one_cycle", 8'h06, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        jump_to(8'h05, 3'd0, 1'b0, 1'b0);
        load_i = 1'b1; cond_i = 3'b101; target_i = 8'h06; pc_enable_i = 1'b1;
        cyc("jn_not_taken", 8'h06, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        pc_enable_i = 1'b1;
        cyc("fetch_inc", 8'h07, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Condition sweep: every code against every flag combination.
        for (int code = 0; code < 8; code++) begin
            for (int fl = 0; fl < 8; fl++) begin
                logic tk;
                tk = cond_expect(code, fl);
                jump_to(8'h80, 3'd0, 1'b0, 1'b0);
                load_i = 1'b1; cond_i = 3'(code); target_i = 8'h33;
                flag_zero_i = fl[2]; flag_carry_i = fl[1]; flag_negative_i = fl[0];
                cyc($sformatf("cond_sweep_c%0d_f%0d", code, fl),
                    tk ? 8'h33 : 8'h80, tk, 3'd0, 1'b0, 1'b0, 1'b0);
            end
        end

        // Nested calls up to the full stack, overflow, then unwinding.
        do_reset();
        jump_to(8'h10, 3'd0, 1'b0, 1'b0);
        call_i = 1'b1; target_i = 8'h20;
        cyc("call1", 8'h20, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        call_i = 1'b1; target_i = 8'h30;
        cyc("call2", 8'h30, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        call_i = 1'b1; target_i = 8'h40;
        cyc("call3", 8'h40, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        call_i = 1'b1; target_i = 8'h50;
        cyc("call4_full", 8'h50, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        call_i = 1'b1; target_i = 8'h60;
        cyc("call_overflow", 8'h50, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0);
        ret_i = 1'b1;
        cyc("ret1", 8'h40, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        ret_i = 1'b1;
        cyc("ret2", 8'h30, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        ret_i = 1'b1;
        cyc("ret3", 8'h20, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        ret_i = 1'b1;
        cyc("ret4", 8'h10, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);

        // Underflow and counter wrap.
        ret_i = 1'b1;
        cyc("ret_underflow", 8'h10, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        jump_to(8'hFF, 3'd0, 1'b1, 1'b1);
        pc_enable_i = 1'b1;
        cyc("wrap", 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0);

        // Priority between simultaneous requests.
        do_reset();
        jump_to(8'h10, 3'd0, 1'b0, 1'b0);
        call_i = 1'b1; target_i = 8'h20;
        cyc("prio_setup_call", 8'h20, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        ret_i = 1'b1; call_i = 1'b1; load_i = 1'b1; target_i = 8'h77;
        cyc("prio_ret_wins", 8'h10, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        call_i = 1'b1; cond_i = 3'b111; target_i = 8'h99; pc_enable_i = 1'b1;
        cyc("call_false_inc", 8'h11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        call_i = 1'b1; cond_i = 3'b001; load_i = 1'b1; target_i = 8'h44;
        cyc("call_false_load_true", 8'h11, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        call_i = 1'b1; cond_i = 3'b010; target_i = 8'h44;
        cyc("call_jnz", 8'h44, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        ret_i = 1'b1;
        cyc("back_to_back_ret", 8'h11, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);

        // Halt latch ignores everything after it.
        jump_to(8'h0A, 3'd0, 1'b0, 1'b0);
        halt_i = 1'b1; pc_enable_i = 1'b1;
        cyc("halt", 8'h0A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        load_i = 1'b1; target_i = 8'h55;
        cyc("halt_ignore_load", 8'h0A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        call_i = 1'b1; target_i = 8'h55;
        cyc("halt_ignore_call", 8'h0A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        ret_i = 1'b1; pc_enable_i = 1'b1;
        cyc("halt_ignore_ret_inc", 8'h0A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // Reset during a call cycle drops the push.
        do_reset();
        jump_to(8'h30, 3'd0, 1'b0, 1'b0);
        reset = 1'b1; call_i = 1'b1; target_i = 8'h40;
        cyc("reset_during_call", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        ret_i = 1'b1;
        cyc("stack_empty_after_reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, wanted 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
